ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage.sv | 206 ++++++++++++++++++++
 tb/tb_ex_operand_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// Decode-to-execute pipeline register with operand forwarding, ALU control
// generation, load-use hazard detection and bubble insertion.
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [1:0]      id_class,
  input  logic [2:0]      id_funct3,
  input  logic            id_funct7b5,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            fwd1_we,
  input  logic [RA_W-1:0] fwd1_rd,
  input  logic [XLEN-1:0] fwd1_data,
  input  logic            fwd2_we,
  input  logic [RA_W-1:0] fwd2_rd,
  input  logic [XLEN-1:0] fwd2_data,
  input  logic            flush,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_r1,
  output logic [XLEN-1:0] ex_r2,
  output logic [3:0]      ex_control,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_illegal,
  output logic            stall
);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_XOR = 4'b0111;
  localparam logic [3:0] ALU_BEQ = 4'b1000;
  localparam logic [3:0] ALU_BNE = 4'b1001;
  localparam logic [3:0] ALU_ILL = 4'b1111;

  localparam logic [1:0] CLS_R   = 2'b00;
  localparam logic [1:0] CLS_I   = 2'b01;
  localparam logic [1:0] CLS_MEM = 2'b10;
  localparam logic [1:0] CLS_BR  = 2'b11;

  logic            r_valid;
  logic [XLEN-1:0] r_r1;
  logic [XLEN-1:0] r_r2;
  logic [3:0]      r_control;
  logic [XLEN-1:0] r_store_data;
  logic [RA_W-1:0] r_rd;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_branch;
  logic            r_illegal;

  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;
  logic [XLEN-1:0] w_op2;
  logic [3:0]      w_control;
  logic            w_illegal;
  logic            w_use_rs2;
  logic            w_hazard;
  logic            w_stall;
  logic            w_bubble;

  // EX/MEM candidate outranks MEM/WB; register zero is hardwired.
  function automatic logic [XLEN-1:0] fwd_select(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] rf_data,
    input logic            f1_we,
    input logic [RA_W-1:0] f1_rd,
    input logic [XLEN-1:0] f1_data,
    input logic            f2_we,
    input logic [RA_W-1:0] f2_rd,
    input logic [XLEN-1:0] f2_data
  );
    logic [XLEN-1:0] result;
    if (rs == '0) begin
      result = '0;
    end else if (f1_we && (f1_rd == rs)) begin
      result = f1_data;
    end else if (f2_we && (f2_rd == rs)) begin
      result = f2_data;
    end else begin
      result = rf_data;
    end
    return result;
  endfunction

  always_comb begin
    w_fwd_rs1 = fwd_select(id_rs1, id_rs1_data, fwd1_we, fwd1_rd, fwd1_data,
                           fwd2_we, fwd2_rd, fwd2_data);
    w_fwd_rs2 = fwd_select(id_rs2, id_rs2_data, fwd1_we, fwd1_rd, fwd1_data,
                           fwd2_we, fwd2_rd, fwd2_data);
  end

  always_comb begin
    w_control = ALU_ADD;
    w_illegal = 1'b0;
    case (id_class)
      CLS_R, CLS_I: begin
        case (id_funct3)
          3'b000: w_control = (id_class == CLS_R && id_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: w_control = ALU_SLL;
          3'b010: w_control = ALU_SLT;
          3'b100: w_control = ALU_XOR;
          3'b101: begin
            // No arithmetic shift in this ALU, so the SRA encoding is rejected.
            if (id_funct7b5) begin
              w_illegal = 1'b1;
            end else begin
              w_control = ALU_SRL;
            end
          end
          3'b110: w_control = ALU_OR;
          3'b111: w_control = ALU_AND;
          default: w_illegal = 1'b1;
        endcase
      end
      CLS_MEM: w_control = ALU_ADD;
      CLS_BR: begin
        case (id_funct3)
          3'b000:  w_control = ALU_BEQ;
          3'b001:  w_control = ALU_BNE;
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_control = ALU_ILL;
    end
  end

  always_comb begin
    w_use_rs2 = (id_class != CLS_I);
    w_op2     = (id_class == CLS_I || id_class == CLS_MEM) ? id_imm : w_fwd_rs2;
  end

  // Load in EX whose result the decode slot needs cannot be forwarded in time.
  always_comb begin
    w_hazard = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
               ((r_rd == id_rs1) || (w_use_rs2 && (r_rd == id_rs2)));
    w_stall  = w_hazard && !flush;
    w_bubble = flush || !id_valid || w_stall;
  end

  assign stall = w_stall;

  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      r_valid      <= 1'b0;
      r_r1         <= '0;
      r_r2         <= '0;
      r_control    <= ALU_ADD;
      r_store_data <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_illegal    <= 1'b0;
    end else begin
      r_valid      <= 1'b1;
      r_r1         <= w_fwd_rs1;
      r_r2         <= w_op2;
      r_control    <= w_control;
      r_store_data <= w_fwd_rs2;
      r_rd         <= id_rd;
      r_reg_write  <= id_reg_write && !w_illegal;
      r_mem_read   <= id_mem_read && !w_illegal;
      r_mem_write  <= id_mem_write && !w_illegal;
      r_branch     <= (id_class == CLS_BR) && !w_illegal;
      r_illegal    <= w_illegal;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_r1         = r_r1;
  assign ex_r2         = r_r2;
  assign ex_control    = r_control;
  assign ex_store_data = r_store_data;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_branch     = r_branch;
  assign ex_illegal    = r_illegal;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed and randomized checks of ex_operand_stage against a cycle-level
// reference model of the pipeline register, forwarding and hazard rules.
module tb_ex_operand_stage;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  // ALU code indexed by funct3 for R/I-type; 4'hF marks an unmapped funct3.
  localparam logic [3:0] ALU_TBL [0:7] = '{4'h0, 4'h3, 4'h4, 4'hF, 4'h7, 4'h5, 4'h2, 4'h1};

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic [3:0]      ctrl;
    logic [XLEN-1:0] sd;
    logic [RA_W-1:0] rd;
    logic            rw;
    logic            mr;
    logic            mw;
    logic            br;
    logic            ill;
  } ex_t;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid;
  logic [1:0]      id_class;
  logic [2:0]      id_funct3;
  logic            id_funct7b5;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic [RA_W-1:0] id_rs1, id_rs2, id_rd;
  logic            id_reg_write, id_mem_read, id_mem_write;
  logic            fwd1_we, fwd2_we;
  logic [RA_W-1:0] fwd1_rd, fwd2_rd;
  logic [XLEN-1:0] fwd1_data, fwd2_data;
  logic            flush;
  logic            ex_valid;
  logic [XLEN-1:0] ex_r1, ex_r2, ex_store_data;
  logic [3:0]      ex_control;
  logic [RA_W-1:0] ex_rd;
  logic            ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
  logic            stall;

  int   n_vec = 0;
  int   n_err = 0;
  ex_t  m = '0;
  logic last_stall;
  bit   m_last_stall;

  ex_operand_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_class(id_class),
    .id_funct3(id_funct3), .id_funct7b5(id_funct7b5),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .fwd1_we(fwd1_we), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
    .fwd2_we(fwd2_we), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data),
    .flush(flush), .ex_valid(ex_valid), .ex_r1(ex_r1), .ex_r2(ex_r2),
    .ex_control(ex_control), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] rf);
    if (rs == 0) return '0;
    if (fwd1_we && fwd1_rd == rs) return fwd1_data;
    if (fwd2_we && fwd2_rd == rs) return fwd2_data;
    return rf;
  endfunction

  function automatic bit model_stall(input ex_t c);
    return c.valid && c.mr && (c.rd != 0) && id_valid && !flush &&
           ((c.rd == id_rs1) || ((c.rd == id_rs2) && (id_class != 2'b01)));
  endfunction

  function automatic ex_t model_next(input ex_t c);
    ex_t        n;
    logic [3:0] op;
    bit         ill;
    n = '0;
    if (reset || flush || !id_valid || model_stall(c)) return n;
    if (id_class == 2'b10) begin
      op = 4'h0;
    end else if (id_class == 2'b11) begin
      op = (id_funct3 == 3'd0) ? 4'h8 : (id_funct3 == 3'd1) ? 4'h9 : 4'hF;
    end else begin
      op = ALU_TBL[id_funct3];
      if (id_funct3 == 3'd0 && id_class == 2'b00 && id_funct7b5) op = 4'h6;
      if (id_funct3 == 3'd5 && id_funct7b5) op = 4'hF;
    end
    ill     = (op == 4'hF);
    n.valid = 1'b1;
    n.r1    = fwd(id_rs1, id_rs1_data);
    n.sd    = fwd(id_rs2, id_rs2_data);
    n.r2    = (id_class == 2'b01 || id_class == 2'b10) ? id_imm : n.sd;
    n.ctrl  = op;
    n.rd    = id_rd;
    n.rw    = id_reg_write && !ill;
    n.mr    = id_mem_read && !ill;
    n.mw    = id_mem_write && !ill;
    n.br    = (id_class == 2'b11) && !ill;
    n.ill   = ill;
    return n;
  endfunction

  // One clock: stall checked at the negedge, all registered outputs after the edge.
  task automatic tick();
    ex_t nxt;
    @(negedge clk);
    last_stall   = stall;
    m_last_stall = model_stall(m);
    check("stall", {63'd0, stall}, {63'd0, m_last_stall});
    nxt = model_next(m);
    @(posedge clk);
    m = nxt;
    #1;
    check("ex_valid",      {63'd0, ex_valid},       {63'd0, m.valid});
    check("ex_r1",         {32'd0, ex_r1},          {32'd0, m.r1});
    check("ex_r2",         {32'd0, ex_r2},          {32'd0, m.r2});
    check("ex_control",    {60'd0, ex_control},     {60'd0, m.ctrl});
    check("ex_store_data", {32'd0, ex_store_data},  {32'd0, m.sd});
    check("ex_rd",         {59'd0, ex_rd},          {59'd0, m.rd});
    check("ex_reg_write",  {63'd0, ex_reg_write},   {63'd0, m.rw});
    check("ex_mem_read",   {63'd0, ex_mem_read},    {63'd0, m.mr});
    check("ex_mem_write",  {63'd0, ex_mem_write},   {63'd0, m.mw});
    check("ex_branch",     {63'd0, ex_branch},      {63'd0, m.br});
    check("ex_illegal",    {63'd0, ex_illegal},     {63'd0, m.ill});
  endtask

  task automatic clear_inputs();
    reset = 1'b0; id_valid = 1'b1; id_class = 2'b00; id_funct3 = 3'd0; id_funct7b5 = 1'b0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
    fwd1_we = 1'b0; fwd1_rd = '0; fwd1_data = '0;
    fwd2_we = 1'b0; fwd2_rd = '0; fwd2_data = '0; flush = 1'b0;
  endtask

  task automatic set_load_in_decode();
    clear_inputs();
    id_class = 2'b10; id_funct3 = 3'd2; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd5;
    id_imm = 32'h10; id_reg_write = 1'b1; id_mem_read = 1'b1;
  endtask

  task automatic set_consumer_of_r5();
    clear_inputs();
    id_class = 2'b00; id_rs1 = 5'd1; id_rs2 = 5'd5; id_rd = 5'd7;
    id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_reg_write = 1'b1;
  endtask

  task automatic randomize_inputs();
    reset        = ($urandom_range(0, 39) == 0);
    flush        = ($urandom_range(0, 15) == 0);
    fwd1_we      = 1'($urandom_range(0, 1));
    fwd1_rd      = 5'($urandom_range(0, 7));
    fwd1_data    = $urandom;
    fwd2_we      = 1'($urandom_range(0, 1));
    fwd2_rd      = 5'($urandom_range(0, 7));
    fwd2_data    = $urandom;
    // A stalled slot is re-presented unchanged, as the upstream stage would.
    if (!m_last_stall) begin
      id_valid     = ($urandom_range(0, 7) != 0);
      id_class     = 2'($urandom_range(0, 3));
      id_funct3    = 3'($urandom_range(0, 7));
      id_funct7b5  = 1'($urandom_range(0, 1));
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      id_reg_write = 1'($urandom_range(0, 1));
      id_mem_read  = ($urandom_range(0, 2) == 0);
      id_mem_write = ($urandom_range(0, 3) == 0);
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1; flush = 1'b1; id_funct3 = 3'd3;
    tick();
    check("rst_valid", {63'd0, ex_valid}, 64'd0);
    check("rst_ctrl", {60'd0, ex_control}, 64'd0);

    // Post-reset: stall must be low and a SUB loads with latency 1.
    clear_inputs();
    id_funct7b5 = 1'b1; id_rs1 = 5'd3; id_rs1_data = 32'd10;
    id_rs2 = 5'd4; id_rs2_data = 32'd4; id_rd = 5'd6; id_reg_write = 1'b1;
    tick();
    check("post_rst_stall", {63'd0, last_stall}, 64'd0);
    check("sub_ctrl", {60'd0, ex_control}, 64'h6);
    check("sub_r1", {32'd0, ex_r1}, 64'd10);
    check("sub_r2", {32'd0, ex_r2}, 64'd4);
    check("sub_valid", {63'd0, ex_valid}, 64'd1);

    clear_inputs();
    id_class = 2'b01; id_funct3 = 3'd6; id_imm = 32'h0F; id_rs1 = 5'd3; id_rs1_data = 32'h99;
    fwd1_we = 1'b1; fwd1_rd = 5'd3; fwd1_data = 32'hF0;
    fwd2_we = 1'b1; fwd2_rd = 5'd3; fwd2_data = 32'h55;
    tick();
    check("ori_r1", {32'd0, ex_r1}, 64'hF0);
    check("ori_r2", {32'd0, ex_r2}, 64'h0F);
    check("ori_ctrl", {60'd0, ex_control}, 64'h2);

    clear_inputs();
    id_class = 2'b11; id_funct3 = 3'd1; id_rs1 = 5'd0; id_rs1_data = 32'h123;
    fwd1_we = 1'b1; fwd1_rd = 5'd0; fwd1_data = 32'd7;
    tick();
    check("bne_r1", {32'd0, ex_r1}, 64'd0);
    check("bne_ctrl", {60'd0, ex_control}, 64'h9);
    check("bne_branch", {63'd0, ex_branch}, 64'd1);

    // Load-use: one stall cycle, a bubble, then the consumer issues.
    set_load_in_decode();
    tick();
    set_consumer_of_r5();
    tick();
    check("lu_stall", {63'd0, last_stall}, 64'd1);
    check("lu_bubble", {63'd0, ex_valid}, 64'd0);
    tick();
    check("lu_stall_clr", {63'd0, last_stall}, 64'd0);
    check("lu_issue", {63'd0, ex_valid}, 64'd1);

    set_load_in_decode();
    tick();
    set_consumer_of_r5();
    flush = 1'b1;
    tick();
    check("flush_stall", {63'd0, last_stall}, 64'd0);
    check("flush_bubble", {63'd0, ex_valid}, 64'd0);

    // Reset during a stall drops it; the same slot loads right after.
    set_load_in_decode();
    tick();
    set_consumer_of_r5();
    reset = 1'b1;
    tick();
    check("rst_mid_valid", {63'd0, ex_valid}, 64'd0);
    reset = 1'b0;
    tick();
    check("rst_mid_stall", {63'd0, last_stall}, 64'd0);
    check("rst_mid_load", {63'd0, ex_valid}, 64'd1);

    clear_inputs();
    id_funct3 = 3'd3; id_reg_write = 1'b1; id_rs1 = 5'd2; id_rs1_data = 32'hABCD;
    tick();
    check("ill_ctrl", {60'd0, ex_control}, 64'hF);
    check("ill_flag", {63'd0, ex_illegal}, 64'd1);
    check("ill_rw", {63'd0, ex_reg_write}, 64'd0);
    reset = 1'b1;
    tick();
    check("ill_rst_ctrl", {60'd0, ex_control}, 64'd0);
    check("ill_rst_ill", {63'd0, ex_illegal}, 64'd0);
    check("ill_rst_r1", {32'd0, ex_r1}, 64'd0);

    clear_inputs();
    m_last_stall = 1'b0;
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
